// File: rtl/execute.sv
// EX stage: integer ALU, optional RV32M multiply/iterative divide.
// Mul/div hardware is built only when RV5STAGE_MULDIV_EN is defined.
package execute_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_op;
    logic       is_muldiv;
    logic       mem_read;
    logic       mem_write;
  } decode_info_t;

  typedef struct packed {
    logic       stall_req;
    logic [3:0] flush_req;
  } pipe_request_t;
endpackage

module execute
  import execute_pkg::*;
#(
  parameter int unsigned DIV_BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  decode_info_t  info,
  input  logic [31:0]   op_a,
  input  logic [31:0]   op_b,
  input  logic [31:0]   store_data,
  output pipe_request_t req,
  output logic [31:0]   result,
  output logic [31:0]   data_ff,
  output decode_info_t  info_ff
);

  logic [31:0] alu_res;
  logic [31:0] ex_res;
  logic        busy_stall;
  logic        bubble;
  logic [4:0]  shamt;
  logic        sub_sel;

  always_comb begin
    shamt   = op_b[4:0];
    sub_sel = info.is_op && info.funct7[5];
    alu_res = '0;
    if (info.mem_read || info.mem_write) begin
      alu_res = op_a + op_b;
    end else begin
      unique case (info.funct3)
        3'd0: alu_res = sub_sel ? op_a - op_b : op_a + op_b;
        3'd1: alu_res = op_a << shamt;
        3'd2: alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
        3'd3: alu_res = {31'b0, op_a < op_b};
        3'd4: alu_res = op_a ^ op_b;
        3'd5: alu_res = info.funct7[5]
                        ? $unsigned($signed(op_a) >>> shamt)
                        : op_a >> shamt;
        3'd6: alu_res = op_a | op_b;
        3'd7: alu_res = op_a & op_b;
        default: alu_res = '0;
      endcase
    end
  end

`ifdef RV5STAGE_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  localparam int unsigned STEPS = 32 / DIV_BITS_PER_CYCLE;
  localparam logic [5:0]  LAST  = 6'(STEPS - 1);

  div_state_e  state, state_nxt;
  logic [5:0]  count;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        is_rem_q, q_neg_q, r_neg_q;

  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mul_res, abs_a, abs_b, quick, div_res;
  logic [31:0] s_rem, s_quo;
  logic        is_div, dsigned, drem, a_neg, b_neg;
  logic        div0, ovf, ge, start;

  always_comb begin
    ext_a = {{32{op_a[31] & (info.funct3 == 3'd1 ||
                             info.funct3 == 3'd2)}}, op_a};
    ext_b = {{32{op_b[31] & (info.funct3 == 3'd1)}}, op_b};
    prod  = ext_a * ext_b;
    mul_res = (info.funct3 == 3'd0) ? prod[31:0] : prod[63:32];

    is_div  = info.is_muldiv && info.funct3[2];
    dsigned = !info.funct3[0];
    drem    = info.funct3[1];
    a_neg   = dsigned & op_a[31];
    b_neg   = dsigned & op_b[31];
    abs_a   = a_neg ? -op_a : op_a;
    abs_b   = b_neg ? -op_b : op_b;
    div0    = (op_b == '0);
    ovf     = dsigned && op_a == 32'h8000_0000 && op_b == '1;
    quick   = drem ? (div0 ? op_a : '0)
                   : (div0 ? '1 : 32'h8000_0000);

    // restoring steps; the partial remainder's top bit forces a subtract
    s_rem = rem_q;
    s_quo = quo_q;
    ge    = 1'b0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      ge = s_rem[31] || ({s_rem, s_quo[31]} >= {1'b0, dvs_q});
      s_rem = ge ? {s_rem[30:0], s_quo[31]} - dvs_q
                 : {s_rem[30:0], s_quo[31]};
      s_quo = {s_quo[30:0], ge};
    end

    div_res = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                       : (q_neg_q ? -quo_q : quo_q);
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    busy_stall = 1'b0;
    bubble     = 1'b0;
    ex_res     = info.is_muldiv ? (info.funct3[2] ? quick : mul_res)
                                : alu_res;
    unique case (state)
      IDLE: begin
        if (is_div && !flush && !div0 && !ovf) begin
          start      = 1'b1;
          busy_stall = 1'b1;
          bubble     = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        busy_stall = 1'b1;
        bubble     = 1'b1;
        if (count == LAST) state_nxt = DONE;
      end
      DONE: begin
        ex_res = div_res;
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        quo_q    <= abs_a;
        rem_q    <= '0;
        dvs_q    <= abs_b;
        count    <= '0;
        is_rem_q <= drem;
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
      end else if (state == BUSY) begin
        quo_q <= s_quo;
        rem_q <= s_rem;
        count <= count + 6'd1;
      end
    end
  end
`else
  assign busy_stall = 1'b0;
  assign bubble     = 1'b0;
  assign ex_res     = info.is_muldiv ? '0 : alu_res;
`endif

  // reset drops the request at once, before the FSM register settles
  assign req.stall_req = busy_stall && !rst;
  assign req.flush_req = 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      data_ff <= '0;
      info_ff <= '0;
    end else if (flush) begin
      result  <= '0;
      data_ff <= '0;
      info_ff <= '0;
    end else if (!stall) begin
      if (bubble) begin
        result  <= '0;
        data_ff <= '0;
        info_ff <= '0;
      end else begin
        result  <= ex_res;
        data_ff <= store_data;
        info_ff <= info;
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: directed ALU, mul and divide vectors.
// Expectations adapt to whether RV5STAGE_MULDIV_EN is defined.
module tb_execute;
  import execute_pkg::*;

`ifdef RV5STAGE_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall, flush;
  decode_info_t  info;
  logic [31:0]   op_a, op_b, store_data;
  pipe_request_t req;
  logic [31:0]   result, data_ff;
  decode_info_t  info_ff;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]  res;
    logic [31:0]  data;
    decode_info_t inf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  execute dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .info(info), .op_a(op_a), .op_b(op_b),
    .store_data(store_data), .req(req), .result(result),
    .data_ff(data_ff), .info_ff(info_ff)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic decode_info_t mk(logic op, logic md, logic mr,
                                      logic mw, logic [2:0] f3,
                                      logic [6:0] f7);
    decode_info_t d;
    d = '0;
    d.valid = 1'b1;
    d.rd = 5'd3;
    d.is_op = op;
    d.is_muldiv = md;
    d.mem_read = mr;
    d.mem_write = mw;
    d.funct3 = f3;
    d.funct7 = f7;
    return d;
  endfunction

  task automatic nop();
    info = '0;
    op_a = '0;
    op_b = '0;
    store_data = '0;
    stall = 1'b0;
  endtask

  // monitor: every unstalled edge that commits a valid instruction
  logic s_st, s_rst;
  exp_t e;
  always begin
    @(posedge clk);
    s_st  = stall;
    s_rst = rst;
    #1;
    if (!s_st && !s_rst && info_ff.valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("data_ff", data_ff, e.data);
        chk("info_ff", 32'(info_ff), 32'(e.inf));
      end
    end
  end

  task automatic issue(decode_info_t i, logic [31:0] a, logic [31:0] b,
                       logic [31:0] sd, logic [31:0] res,
                       int exp_stall, int hold = 0);
    int n, cyc;
    bit done;
    exp_t x;
    @(negedge clk);
    info = i;
    op_a = a;
    op_b = b;
    store_data = sd;
    x.res = res;
    x.data = sd;
    x.inf = i;
    sb.push_back(x);
    n = 0;
    cyc = 0;
    forever begin
      #1;
      if (req.stall_req) n++;
      if (!req.stall_req && hold > 0) begin
        stall = 1'b1;
        hold--;
      end else begin
        stall = 1'b0;
      end
      done = !req.stall_req && !stall;
      @(negedge clk);
      cyc++;
      if (stall) chk("hold_result", result, 32'h0);
      if (done) break;
      if (cyc > 100) begin
        checks++;
        failures++;
        $display("FAIL timeout actual=%0d required=<100", cyc);
        break;
      end
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    nop();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] SD = 32'hA5A5_0001;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    nop();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_data", data_ff, 32'h0);
    chk("rst_info", 32'(info_ff), 32'h0);
    chk("rst_stall_req", 32'(req.stall_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(mk(1,0,0,0,3'd0,7'h00), 32'hFFFFFFFF, 32'd1, SD, 32'h0, 0);
    issue(mk(1,0,0,0,3'd0,7'h20), 32'd5, 32'd7, SD, 32'hFFFFFFFE, 0);
    issue(mk(0,0,0,0,3'd0,7'h20), 32'd5, 32'h400, SD, 32'h405, 0);
    issue(mk(1,0,0,0,3'd1,7'h00), 32'd1, 32'h3F, SD, 32'h80000000, 0);
    issue(mk(1,0,0,0,3'd2,7'h00), 32'hFFFFFFFF, 32'd1, SD, 32'd1, 0);
    issue(mk(1,0,0,0,3'd3,7'h00), 32'hFFFFFFFF, 32'd1, SD, 32'd0, 0);
    issue(mk(1,0,0,0,3'd3,7'h00), 32'd1, 32'hFFFFFFFF, SD, 32'd1, 0);
    issue(mk(1,0,0,0,3'd4,7'h00), 32'hF0F0F0F0, 32'hFF00FF00, SD,
          32'h0FF00FF0, 0);
    issue(mk(1,0,0,0,3'd5,7'h00), 32'h80000000, 32'd4, SD,
          32'h08000000, 0);
    issue(mk(1,0,0,0,3'd5,7'h20), 32'h80000000, 32'd4, SD,
          32'hF8000000, 0);
    issue(mk(0,0,0,0,3'd5,7'h20), 32'h80000000, 32'h404, SD,
          32'hF8000000, 0);
    issue(mk(1,0,0,0,3'd6,7'h00), 32'hF0F0F0F0, 32'h0F0F0000, SD,
          32'hFFFFF0F0, 0);
    issue(mk(1,0,0,0,3'd7,7'h00), 32'hF0F0F0F0, 32'hFF00FF00, SD,
          32'hF000F000, 0);
    issue(mk(0,0,1,0,3'd2,7'h00), 32'h1000, 32'hFFFFFFFC, 32'hDEADBEEF,
          32'h0FFC, 0);
    issue(mk(0,0,0,1,3'd2,7'h00), 32'h2000, 32'd8, 32'h12345678,
          32'h2008, 0);

    issue(mk(1,1,0,0,3'd0,7'h01), 32'd6, 32'd7, SD,
          MD ? 32'd42 : 32'd0, 0);
    issue(mk(1,1,0,0,3'd1,7'h01), 32'hFFFFFFFE, 32'd3, SD,
          MD ? 32'hFFFFFFFF : 32'd0, 0);
    issue(mk(1,1,0,0,3'd1,7'h01), 32'h80000000, 32'h80000000, SD,
          MD ? 32'h40000000 : 32'd0, 0);
    issue(mk(1,1,0,0,3'd2,7'h01), 32'hFFFFFFFF, 32'hFFFFFFFF, SD,
          MD ? 32'hFFFFFFFF : 32'd0, 0);
    issue(mk(1,1,0,0,3'd3,7'h01), 32'hFFFFFFFF, 32'hFFFFFFFF, SD,
          MD ? 32'hFFFFFFFE : 32'd0, 0);
    issue(mk(1,1,0,0,3'd3,7'h01), 32'h80000000, 32'd2, SD,
          MD ? 32'd1 : 32'd0, 0);

    issue(mk(1,1,0,0,3'd4,7'h01), 32'hFFFFFFF9, 32'd2, SD,
          MD ? 32'hFFFFFFFD : 32'd0, MD ? 33 : 0);
    issue(mk(1,1,0,0,3'd6,7'h01), 32'hFFFFFFF9, 32'd2, SD,
          MD ? 32'hFFFFFFFF : 32'd0, MD ? 33 : 0);
    issue(mk(1,1,0,0,3'd5,7'h01), 32'd100, 32'd7, SD,
          MD ? 32'd14 : 32'd0, MD ? 33 : 0, 3);
    issue(mk(1,1,0,0,3'd7,7'h01), 32'd100, 32'd7, SD,
          MD ? 32'd2 : 32'd0, MD ? 33 : 0);
    issue(mk(1,1,0,0,3'd4,7'h01), 32'd7, 32'hFFFFFFFE, SD,
          MD ? 32'hFFFFFFFD : 32'd0, MD ? 33 : 0);
    issue(mk(1,1,0,0,3'd6,7'h01), 32'd7, 32'hFFFFFFFE, SD,
          MD ? 32'd1 : 32'd0, MD ? 33 : 0);
    issue(mk(1,1,0,0,3'd5,7'h01), 32'hFFFFFFF9, 32'd2, SD,
          MD ? 32'h7FFFFFFC : 32'd0, MD ? 33 : 0);

    issue(mk(1,1,0,0,3'd5,7'h01), 32'd100, 32'd0, SD,
          MD ? 32'hFFFFFFFF : 32'd0, 0);
    issue(mk(1,1,0,0,3'd7,7'h01), 32'd100, 32'd0, SD,
          MD ? 32'd100 : 32'd0, 0);
    issue(mk(1,1,0,0,3'd4,7'h01), 32'h80000000, 32'hFFFFFFFF, SD,
          MD ? 32'h80000000 : 32'd0, 0);
    issue(mk(1,1,0,0,3'd6,7'h01), 32'h80000000, 32'hFFFFFFFF, SD,
          32'd0, 0);
    issue(mk(1,1,0,0,3'd4,7'h01), 32'hFFFFFFF9, 32'd0, SD,
          MD ? 32'hFFFFFFFF : 32'd0, 0);
    issue(mk(1,1,0,0,3'd6,7'h01), 32'hFFFFFFF9, 32'd0, SD,
          MD ? 32'hFFFFFFF9 : 32'd0, 0);

    // flush a divide five cycles into BUSY
    @(negedge clk);
    info = mk(1,1,0,0,3'd4,7'h01);
    info.valid = 1'b0;
    op_a = 32'hFFFFFFF9;
    op_b = 32'd2;
    store_data = 32'h77;
    repeat (6) @(negedge clk);
    #1;
    chk("busy_stall_req", 32'(req.stall_req), 32'(MD));
    flush = 1'b1;
    nop();
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_stall_req", 32'(req.stall_req), 32'h0);
    chk("flush_info", 32'(info_ff), 32'h0);
    chk("flush_data", data_ff, 32'h0);
    issue(mk(1,0,0,0,3'd0,7'h00), 32'd10, 32'd20, SD, 32'd30, 0);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    info = mk(1,1,0,0,3'd5,7'h01);
    info.valid = 1'b0;
    op_a = 32'd100;
    op_b = 32'd7;
    store_data = 32'h55;
    repeat (10) @(negedge clk);
    #1;
    chk("pre_rst_stall_req", 32'(req.stall_req), 32'(MD));
    rst = 1'b1;
    #1;
    chk("rst_now_stall_req", 32'(req.stall_req), 32'h0);
    chk("rst_now_info", 32'(info_ff), 32'h0);
    chk("rst_now_data", data_ff, 32'h0);
    nop();
    @(negedge clk);
    rst = 1'b0;
    issue(mk(1,0,0,0,3'd0,7'h00), 32'd3, 32'd4, SD, 32'd7, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
